// File: rtl/renkon_conv_wload.sv
// renkon_conv_wload: streams one FSIZE x FSIZE kernel of weights from
// weight memory into the serial weight shift register, tap 0 first.
module renkon_conv_wload #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int FSIZE  = 5,
    parameter int RLAT   = 1
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     start,
    input  logic        [AWIDTH-1:0] base_addr,
    output logic                     mem_re,
    output logic        [AWIDTH-1:0] mem_addr,
    input  logic signed [DWIDTH-1:0] mem_rdata,
    output logic signed [DWIDTH-1:0] read_weight,
    output logic                     wreg_we,
    output logic                     busy,
    output logic                     done
);

    localparam int NTAP = FSIZE * FSIZE;
    localparam int CW   = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NTAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AWIDTH-1:0] base_q;
    logic [CW-1:0]     cnt;
    logic [RLAT-1:0]   pipe;
    logic              accept;
    logic              drained;

    assign accept = (state == IDLE) && start;

    // Pipeline is empty after this cycle once every stage but the
    // output stage is clear and no new read is being issued.
    assign drained = (RLAT'({pipe, 1'b0}) == '0);

    assign mem_addr    = base_q + AWIDTH'(cnt);
    assign wreg_we     = pipe[RLAT-1];
    assign read_weight = mem_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_re = 1'b1;
                busy   = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drained) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Base latch and tap counter; counter parks on the last tap so the
    // address holds while no reads are issued.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            base_q <= '0;
            cnt    <= '0;
        end else if (accept) begin
            base_q <= base_addr;
            cnt    <= '0;
        end else if (mem_re && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Read-enable delay line matching the memory read latency.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            pipe <= '0;
        end else begin
            pipe <= RLAT'({pipe, mem_re});
        end
    end

endmodule

// File: tb/tb_renkon_conv_wload.sv
// Bench for renkon_conv_wload: three instances (RLAT 1, 2, 4) share
// stimulus; each has its own memory model, shift register and monitor.
module tb_renkon_conv_wload;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic xrst;
    logic start;
    logic [11:0] base_addr;

    logic [2:0] re;
    logic [2:0] we;
    logic [2:0] bsy;
    logic [2:0] dn;
    logic [11:0] addr [3];
    logic signed [15:0] rdata [3];
    logic signed [15:0] rw [3];

    logic signed [15:0] mem [4096];
    logic signed [15:0] rdq [3][4];
    logic signed [15:0] wsr [3][25];

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    int re_n [3] = '{0, 0, 0};
    int we_n [3] = '{0, 0, 0};
    int dn_n [3] = '{0, 0, 0};
    int bs_n [3] = '{0, 0, 0};
    int re_cyc [3][DEPTH];
    logic [11:0] re_addr [3][DEPTH];
    int we_cyc [3][DEPTH];
    logic signed [15:0] we_dat [3][DEPTH];
    int dn_cyc [3][64];

    int b_re [3];
    int b_we [3];
    int b_dn [3];
    int b_bs [3];

    int st_n;
    int st_cyc [64];
    logic [11:0] st_base [64];
    int acc_n [3];
    int acc_cyc [3][16];
    logic [11:0] acc_base [3][16];

    always #5 clk = ~clk;

    renkon_conv_wload #(.DWIDTH(16), .AWIDTH(12), .FSIZE(5), .RLAT(1)) u_l1 (
        .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr),
        .mem_re(re[0]), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
        .read_weight(rw[0]), .wreg_we(we[0]), .busy(bsy[0]), .done(dn[0])
    );

    renkon_conv_wload #(.DWIDTH(16), .AWIDTH(12), .FSIZE(5), .RLAT(2)) u_l2 (
        .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr),
        .mem_re(re[1]), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
        .read_weight(rw[1]), .wreg_we(we[1]), .busy(bsy[1]), .done(dn[1])
    );

    renkon_conv_wload #(.DWIDTH(16), .AWIDTH(12), .FSIZE(5), .RLAT(4)) u_l4 (
        .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr),
        .mem_re(re[2]), .mem_addr(addr[2]), .mem_rdata(rdata[2]),
        .read_weight(rw[2]), .wreg_we(we[2]), .busy(bsy[2]), .done(dn[2])
    );

    // Cycle index: value n holds during the period after edge n.
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memories with fixed read latency per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            rdq[k][0] <= (re[k] === 1'b1) ? mem[addr[k]] : 16'sh5a5a;
            for (int j = 1; j < 4; j++) rdq[k][j] <= rdq[k][j-1];
        end
    end
    assign rdata[0] = rdq[0][0];
    assign rdata[1] = rdq[1][1];
    assign rdata[2] = rdq[2][3];

    // Weight shift registers: newest tap enters at 24, oldest ends at 0.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (we[k] === 1'b1) begin
                for (int i = 0; i < 24; i++) wsr[k][i] <= wsr[k][i+1];
                wsr[k][24] <= rw[k];
            end
        end
    end

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (re[k] === 1'b1) begin
                if (re_n[k] < DEPTH) begin
                    re_cyc[k][re_n[k]] <= cyc;
                    re_addr[k][re_n[k]] <= addr[k];
                end
                re_n[k] <= re_n[k] + 1;
            end
            if (we[k] === 1'b1) begin
                if (we_n[k] < DEPTH) begin
                    we_cyc[k][we_n[k]] <= cyc;
                    we_dat[k][we_n[k]] <= rw[k];
                end
                we_n[k] <= we_n[k] + 1;
            end
            if (dn[k] === 1'b1) begin
                if (dn_n[k] < 64) dn_cyc[k][dn_n[k]] <= cyc;
                dn_n[k] <= dn_n[k] + 1;
            end
            if (bsy[k] === 1'b1) bs_n[k] <= bs_n[k] + 1;
        end
    end

    function automatic int lat(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    // Reference: a start is taken when the unit is idle, i.e. no earlier
    // accepted start within the last 27+RLAT cycles.
    function automatic void model();
        for (int k = 0; k < 3; k++) begin
            int nxt;
            nxt = -100000;
            acc_n[k] = 0;
            for (int i = 0; i < st_n; i++) begin
                if (st_cyc[i] >= nxt && acc_n[k] < 16) begin
                    acc_cyc[k][acc_n[k]] = st_cyc[i];
                    acc_base[k][acc_n[k]] = st_base[i];
                    acc_n[k] = acc_n[k] + 1;
                    nxt = st_cyc[i] + 27 + lat(k);
                end
            end
        end
    endfunction

    function automatic logic [11:0] e_addr(int k, int j);
        logic [11:0] a;
        a = acc_base[k][j / 25] + 12'(j % 25);
        return a;
    endfunction

    function automatic int e_re_cyc(int k, int j);
        return acc_cyc[k][j / 25] + 1 + (j % 25);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(int c);
        while (cyc < c) tick();
    endtask

    task automatic begin_test();
        st_n = 0;
        for (int k = 0; k < 3; k++) begin
            b_re[k] = re_n[k];
            b_we[k] = we_n[k];
            b_dn[k] = dn_n[k];
            b_bs[k] = bs_n[k];
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    endtask

    task automatic pulse(logic [11:0] b);
        start = 1'b1;
        base_addr = b;
        st_cyc[st_n] = cyc;
        st_base[st_n] = b;
        st_n = st_n + 1;
        tick();
        start = 1'b0;
        base_addr = 12'($urandom);
    endtask

    task automatic test_reset();
        xrst = 1'b0;
        start = 1'b1;
        base_addr = 12'h123;
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({re[k], we[k], bsy[k], dn[k]} !== 4'b0 || addr[k] !== 12'h0) begin
                $display("FAIL reset_state inst%0d: re/we/busy/done=%b%b%b%b addr=%h want 0000 000",
                         k, re[k], we[k], bsy[k], dn[k], addr[k]);
            end else passes++;
        end
        tick();
        xrst = 1'b1;
        start = 1'b0;
        begin_test();
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (re_n[k] - b_re[k] != 0 || bs_n[k] - b_bs[k] != 0) begin
                $display("FAIL reset_start_ignored inst%0d: reads=%0d busy=%0d want 0 0",
                         k, re_n[k] - b_re[k], bs_n[k] - b_bs[k]);
            end else passes++;
        end
    endtask

    task automatic test_basic();
        int t;
        begin_test();
        fill_mem();
        for (int i = 0; i < 25; i++) mem[12'h040 + i] = 16'(100 + i);
        t = cyc;
        pulse(12'h040);
        repeat (35) tick();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = we_n[k] - b_we[k];
            checks++;
            if (n != 25) $display("FAIL basic_count inst%0d: got %0d want 25", k, n);
            else passes++;
            for (int j = 0; j < n && j < 25; j++) begin
                logic signed [15:0] ed;
                ed = 16'(100 + j);
                checks++;
                if (we_dat[k][b_we[k]+j] !== ed || we_cyc[k][b_we[k]+j] != t + 1 + lat(k) + j)
                    $display("FAIL basic_shift inst%0d tap%0d: got %0d@%0d want %0d@%0d", k, j,
                             we_dat[k][b_we[k]+j], we_cyc[k][b_we[k]+j], ed, t + 1 + lat(k) + j);
                else passes++;
            end
            checks++;
            if (dn_n[k] - b_dn[k] != 1 || dn_cyc[k][b_dn[k]] != t + 26 + lat(k))
                $display("FAIL basic_done inst%0d: count %0d at %0d want 1 at %0d", k,
                         dn_n[k] - b_dn[k], dn_cyc[k][b_dn[k]], t + 26 + lat(k));
            else passes++;
            checks++;
            if (wsr[k][0] !== 16'sd100 || wsr[k][24] !== 16'sd124)
                $display("FAIL basic_wreg inst%0d: w0=%0d w24=%0d want 100 124", k, wsr[k][0], wsr[k][24]);
            else passes++;
            checks++;
            if (bs_n[k] - b_bs[k] != 25 + lat(k))
                $display("FAIL basic_busy inst%0d: got %0d want %0d", k, bs_n[k] - b_bs[k], 25 + lat(k));
            else passes++;
            checks++;
            if (addr[k] !== 12'h058)
                $display("FAIL basic_addr_hold inst%0d: got %h want 058", k, addr[k]);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        begin_test();
        fill_mem();
        pulse(12'hff0);
        repeat (35) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (re_n[k] - b_re[k] != 25 || we_n[k] - b_we[k] != 25)
                $display("FAIL wrap_count inst%0d: reads=%0d shifts=%0d want 25 25", k,
                         re_n[k] - b_re[k], we_n[k] - b_we[k]);
            else passes++;
            for (int j = 0; j < 25; j++) begin
                logic [11:0] a;
                a = 12'hff0 + 12'(j);
                checks++;
                if (re_addr[k][b_re[k]+j] !== a || we_dat[k][b_we[k]+j] !== mem[a])
                    $display("FAIL wrap_tap inst%0d tap%0d: addr %h data %0d want %h %0d", k, j,
                             re_addr[k][b_re[k]+j], we_dat[k][b_we[k]+j], a, mem[a]);
                else passes++;
            end
        end
    endtask

    task automatic test_busy_start();
        int t;
        begin_test();
        fill_mem();
        t = cyc;
        pulse(12'($urandom));
        at(t + 5);  pulse(12'($urandom));
        at(t + 26); pulse(12'($urandom));
        at(t + 28); pulse(12'($urandom));
        at(t + 29); pulse(12'($urandom));
        at(t + 31); pulse(12'($urandom));
        repeat (40) tick();
        model();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = we_n[k] - b_we[k];
            checks++;
            if (n != 50 || dn_n[k] - b_dn[k] != 2)
                $display("FAIL busy_count inst%0d: shifts=%0d dones=%0d want 50 2", k, n, dn_n[k] - b_dn[k]);
            else passes++;
            checks++;
            if (dn_cyc[k][b_dn[k]] != t + 26 + lat(k) || re_cyc[k][b_re[k]+25] != t + 28 + lat(k))
                $display("FAIL busy_restart inst%0d: done@%0d reload@%0d want %0d %0d", k,
                         dn_cyc[k][b_dn[k]], re_cyc[k][b_re[k]+25], t + 26 + lat(k), t + 28 + lat(k));
            else passes++;
            for (int j = 0; j < n && j < 25 * acc_n[k]; j++) begin
                checks++;
                if (we_dat[k][b_we[k]+j] !== mem[e_addr(k, j)] ||
                    we_cyc[k][b_we[k]+j] != e_re_cyc(k, j) + lat(k))
                    $display("FAIL busy_shift inst%0d #%0d: got %0d@%0d want %0d@%0d", k, j,
                             we_dat[k][b_we[k]+j], we_cyc[k][b_we[k]+j],
                             mem[e_addr(k, j)], e_re_cyc(k, j) + lat(k));
                else passes++;
            end
        end
    endtask

    task automatic test_reset_abort();
        int t;
        begin_test();
        fill_mem();
        t = cyc;
        pulse(12'($urandom));
        at(t + 10);
        xrst = 1'b0;
        tick();
        xrst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({re[k], we[k], bsy[k], dn[k]} !== 4'b0 || addr[k] !== 12'h0)
                $display("FAIL abort_state inst%0d: re/we/busy/done=%b%b%b%b addr=%h want 0000 000",
                         k, re[k], we[k], bsy[k], dn[k], addr[k]);
            else passes++;
        end
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (re_n[k] - b_re[k] != 10 || we_n[k] - b_we[k] != 10 - lat(k) ||
                dn_n[k] - b_dn[k] != 0 || bs_n[k] - b_bs[k] != 10)
                $display("FAIL abort_counts inst%0d: re=%0d we=%0d done=%0d busy=%0d want 10 %0d 0 10",
                         k, re_n[k] - b_re[k], we_n[k] - b_we[k], dn_n[k] - b_dn[k],
                         bs_n[k] - b_bs[k], 10 - lat(k));
            else passes++;
        end
        begin_test();
        t = cyc;
        pulse(12'($urandom));
        repeat (35) tick();
        model();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (we_n[k] - b_we[k] != 25 || dn_n[k] - b_dn[k] != 1 || dn_cyc[k][b_dn[k]] != t + 26 + lat(k))
                $display("FAIL abort_reload inst%0d: shifts=%0d dones=%0d done@%0d want 25 1 %0d", k,
                         we_n[k] - b_we[k], dn_n[k] - b_dn[k], dn_cyc[k][b_dn[k]], t + 26 + lat(k));
            else passes++;
            for (int j = 0; j < 25; j++) begin
                checks++;
                if (wsr[k][j] !== mem[e_addr(k, j)])
                    $display("FAIL abort_wreg inst%0d w%0d: got %0d want %0d", k, j, wsr[k][j], mem[e_addr(k, j)]);
                else passes++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        begin_test();
        fill_mem();
        t = cyc;
        start = 1'b1;
        for (int c = 0; c <= 31; c++) begin
            base_addr = (c == 0) ? 12'h000 : 12'h019;
            st_cyc[st_n] = cyc;
            st_base[st_n] = base_addr;
            st_n = st_n + 1;
            tick();
        end
        start = 1'b0;
        repeat (40) tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (we_n[k] - b_we[k] != 50 || dn_n[k] - b_dn[k] != 2)
                $display("FAIL b2b_count inst%0d: shifts=%0d dones=%0d want 50 2", k,
                         we_n[k] - b_we[k], dn_n[k] - b_dn[k]);
            else passes++;
            checks++;
            if (re_cyc[k][b_re[k]+25] != t + 28 + lat(k) || re_addr[k][b_re[k]+25] !== 12'h019)
                $display("FAIL b2b_second inst%0d: first read %h@%0d want 019@%0d", k,
                         re_addr[k][b_re[k]+25], re_cyc[k][b_re[k]+25], t + 28 + lat(k));
            else passes++;
            for (int i = 0; i < 25; i++) begin
                checks++;
                if (wsr[k][i] !== mem[12'h019 + 12'(i)])
                    $display("FAIL b2b_wreg inst%0d w%0d: got %0d want %0d", k, i,
                             wsr[k][i], mem[12'h019 + 12'(i)]);
                else passes++;
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            begin_test();
            fill_mem();
            for (int p = 0; p < 6; p++) begin
                repeat ($urandom_range(0, 39)) tick();
                pulse(12'($urandom));
            end
            repeat (40) tick();
            model();
            for (int k = 0; k < 3; k++) begin
                int n;
                n = we_n[k] - b_we[k];
                checks++;
                if (n != 25 * acc_n[k] || re_n[k] - b_re[k] != 25 * acc_n[k] || dn_n[k] - b_dn[k] != acc_n[k])
                    $display("FAIL rand_count r%0d inst%0d: re=%0d we=%0d done=%0d want %0d %0d %0d", r, k,
                             re_n[k] - b_re[k], n, dn_n[k] - b_dn[k], 25 * acc_n[k], 25 * acc_n[k], acc_n[k]);
                else passes++;
                for (int l = 0; l < acc_n[k] && l < dn_n[k] - b_dn[k]; l++) begin
                    checks++;
                    if (dn_cyc[k][b_dn[k]+l] != acc_cyc[k][l] + 26 + lat(k))
                        $display("FAIL rand_done r%0d inst%0d #%0d: got %0d want %0d", r, k, l,
                                 dn_cyc[k][b_dn[k]+l], acc_cyc[k][l] + 26 + lat(k));
                    else passes++;
                end
                for (int j = 0; j < n && j < 25 * acc_n[k]; j++) begin
                    checks++;
                    if (re_addr[k][b_re[k]+j] !== e_addr(k, j) ||
                        we_dat[k][b_we[k]+j] !== mem[e_addr(k, j)] ||
                        we_cyc[k][b_we[k]+j] != e_re_cyc(k, j) + lat(k))
                        $display("FAIL rand_tap r%0d inst%0d #%0d: addr %h data %0d@%0d want %h %0d@%0d",
                                 r, k, j, re_addr[k][b_re[k]+j], we_dat[k][b_we[k]+j],
                                 we_cyc[k][b_we[k]+j], e_addr(k, j), mem[e_addr(k, j)],
                                 e_re_cyc(k, j) + lat(k));
                    else passes++;
                end
            end
        end
    endtask

    initial begin
        xrst = 1'b0;
        start = 1'b0;
        base_addr = 12'h0;
        test_reset();
        test_basic();
        test_wrap();
        test_busy_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/renkon_conv_wload.md
RENKON_CONV_WLOAD -- requirements
Module: renkon_conv_wload

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, weight data width in bits.
REQ-002 SHALL have parameter AWIDTH, default 12, weight memory address width in bits.
REQ-003 SHALL have parameter FSIZE, default 5, filter side; taps per kernel NTAP = FSIZE*FSIZE (25).
REQ-004 SHALL have parameter RLAT, default 1, weight memory read latency in cycles; legal range 1..4.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 xrst  input  1  reset, synchronous, active-low.
REQ-007 start  input  1  one-cycle request to load one kernel; honoured only in IDLE.
REQ-008 base_addr  input  AWIDTH  address of tap 0, sampled with an accepted start.
REQ-009 mem_re  output  1  weight memory read enable.
REQ-010 mem_addr  output  AWIDTH  weight memory read address.
REQ-011 mem_rdata  input  signed DWIDTH  memory read data, valid exactly RLAT cycles after the matching mem_re.
REQ-012 read_weight  output  signed DWIDTH  serial weight to the weight shift register.
REQ-013 wreg_we  output  1  shift enable to the weight shift register; one shift per high cycle.
REQ-014 busy  output  1  high from the first issue cycle through the last wreg_we cycle.
REQ-015 done  output  1  one-cycle pulse after the final shift of a kernel.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-017 IDLE: start=1 -> ISSUE next cycle; base_addr latched; issue counter cleared.
REQ-018 ISSUE: mem_re=1 every cycle, mem_addr = latched base + counter, counter 0..NTAP-1; after counter NTAP-1 -> DRAIN.
REQ-019 Address add SHALL wrap modulo 2^AWIDTH (base 0xFFF, tap 1 -> 0x000).
REQ-020 wreg_we SHALL equal mem_re delayed by exactly RLAT cycles (shift pipeline of RLAT flops); read_weight SHALL equal mem_rdata in the same cycle, unregistered.
REQ-021 DRAIN: mem_re=0; stay until the delayed-enable pipeline is empty, then -> DONE.
REQ-022 DONE: done=1 for one cycle; -> IDLE next cycle.
REQ-023 Exactly NTAP wreg_we cycles per accepted start, taps delivered in address order, so tap 0 lands in weight0 and tap 24 in weight24.
REQ-024 Timing with start accepted at cycle 0: mem_re cycles 1..25; wreg_we cycles 1+RLAT..25+RLAT; done at cycle 26+RLAT; start accepted again from cycle 27+RLAT.
REQ-025 start in ISSUE, DRAIN or DONE SHALL be ignored, no queuing; base_addr change during a load SHALL have no effect.
REQ-026 busy=1 in ISSUE and DRAIN, 0 in IDLE and DONE.
REQ-027 mem_addr SHALL hold its last value when mem_re=0; read_weight is don't-care when wreg_we=0.

Reset
REQ-028 xrst=0 at a rising edge SHALL force state IDLE, counter 0, delay pipeline cleared, mem_re=0, wreg_we=0, busy=0, done=0, mem_addr=0, from the following cycle.
REQ-029 Reset mid-load SHALL abort with no further wreg_we pulses and no done; partial shifts already issued are not undone.
REQ-030 start asserted together with xrst=0 SHALL be ignored.

Verification
REQ-031 Basic, RLAT=1: memory holds value 100+i at address 0x040+i; start with base 0x040 at cycle 0 -> wreg_we cycles 2..26, read_weight 100..124 in order, done at cycle 27, shift register weight0=100, weight24=124.
REQ-032 Latency sweep: repeat the basic case for RLAT=2 and RLAT=4 -> wreg_we count 25, first wreg_we at cycle 1+RLAT, done at cycle 26+RLAT.
REQ-033 Wrap: base 0xFF0 -> mem_addr 0xFF0..0xFFF then 0x000..0x008; data order preserved.
REQ-034 Busy start: pulse start at cycles 5 and 26 during a load -> exactly 25 shifts and one done; a start in the cycle after done begins a new load.
REQ-035 Reset abort: xrst=0 at cycle 10 of a load -> from cycle 11 mem_re=0, wreg_we=0, busy=0, no done; a following start performs a full correct 25-tap load.
REQ-036 Back-to-back: two kernels at bases 0x000 and 0x019 -> 50 shifts total, second start accepted the cycle after the first done, shift register holds taps of the second kernel.
